// File: rtl/mod16_tx.sv
// -----------------------------------------------------------------------------
// mod16_tx: 16-QAM modulator. This is the transmit-side counterpart of demod16.
//
// It accepts a byte stream and splits each byte into two 4-bit symbols, sending
// the high nibble first. Each symbol is mapped to Gray-coded signed I/Q levels.
// Bits b3b2 drive I and bits b1b0 drive Q, with this mapping:
//   00 -> -3*AMP, 01 -> -AMP, 11 -> +AMP, 10 -> +3*AMP.
// The block also counts the symbols handshaken in the current or last packet.
//
// Handshakes: a byte moves when o_tready && i_tdata_valid at a rising edge. A
// symbol moves when o_sym_valid && i_sym_ready at a rising edge. While
// o_sym_valid is high and i_sym_ready is low, the symbol outputs hold steady.
//
// Ports
//   i_clk                     clock, rising edge
//   i_rst                     synchronous reset, active-low
//   i_tdata / i_tdata_valid / i_tdata_last   input byte stream
//   o_tready                  byte can be accepted this cycle
//   o_sym_i / o_sym_q         signed I/Q levels (WIDTH bits)
//   o_sym_valid / o_sym_last  symbol qualifiers
//   i_sym_ready               downstream accepts the symbol
//   o_packet_size_in_symbols  symbols transferred in the current/last packet
//   o_busy                    a byte is in flight (FSM not empty)
// -----------------------------------------------------------------------------
module mod16_tx #(
    parameter int WIDTH = 8,
    parameter int AMP   = 32,
    parameter int CNT_W = 13
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [7:0]              i_tdata,
    input  logic                    i_tdata_valid,
    input  logic                    i_tdata_last,
    output logic                    o_tready,
    output logic signed [WIDTH-1:0] o_sym_i,
    output logic signed [WIDTH-1:0] o_sym_q,
    output logic                    o_sym_valid,
    output logic                    o_sym_last,
    input  logic                    i_sym_ready,
    output logic [CNT_W-1:0]        o_packet_size_in_symbols,
    output logic                    o_busy
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HI    = 2'd1,
        S_LO    = 2'd2
    } state_t;

    localparam logic signed [WIDTH-1:0] LVL1 = WIDTH'(AMP);
    localparam logic signed [WIDTH-1:0] LVL3 = WIDTH'(3 * AMP);

    state_t     state;
    state_t     state_next;
    logic       accept;
    logic       xfer;
    logic [3:0] lo_nib;     // low nibble waiting behind the presented high symbol
    logic       lo_last;    // packet-last flag belonging to lo_nib
    logic       restart;    // previous transfer closed a packet

    // Gray-coded 2-bit level map for one axis.
    function automatic logic signed [WIDTH-1:0] map_axis(input logic [1:0] b);
        logic signed [WIDTH-1:0] v;
        case (b)
            2'b00:   v = -LVL3;
            2'b01:   v = -LVL1;
            2'b11:   v = LVL1;
            default: v = LVL3;
        endcase
        return v;
    endfunction

    // ---------------- state register ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_EMPTY: if (accept) state_next = S_HI;
            S_HI:    if (xfer)   state_next = S_LO;
            S_LO: begin
                // In S_LO an accept can only happen together with a transfer.
                if (xfer) state_next = accept ? S_HI : S_EMPTY;
            end
            default: state_next = S_EMPTY;
        endcase
    end

    // ---------------- output / handshake logic ----------------
    always_comb begin
        o_tready    = i_rst && ((state == S_EMPTY) || (state == S_LO && i_sym_ready));
        o_sym_valid = (state != S_EMPTY);
        o_busy      = (state != S_EMPTY);
        accept      = o_tready && i_tdata_valid;
        xfer        = o_sym_valid && i_sym_ready;
    end

    // ---------------- symbol datapath ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_sym_i    <= '0;
            o_sym_q    <= '0;
            o_sym_last <= 1'b0;
            lo_nib     <= '0;
            lo_last    <= 1'b0;
        end else if (accept) begin
            // A new byte always presents its high nibble first.
            o_sym_i    <= map_axis(i_tdata[7:6]);
            o_sym_q    <= map_axis(i_tdata[5:4]);
            o_sym_last <= 1'b0;
            lo_nib     <= i_tdata[3:0];
            lo_last    <= i_tdata_last;
        end else if (state == S_HI && xfer) begin
            o_sym_i    <= map_axis(lo_nib[3:2]);
            o_sym_q    <= map_axis(lo_nib[1:0]);
            o_sym_last <= lo_last;
        end else if (state == S_LO && xfer) begin
            o_sym_last <= 1'b0;
        end
    end

    // ---------------- packet symbol counter ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_packet_size_in_symbols <= '0;
            restart                  <= 1'b0;
        end else if (xfer) begin
            if (restart) begin
                o_packet_size_in_symbols <= CNT_W'(1);
            end else if (o_packet_size_in_symbols != {CNT_W{1'b1}}) begin
                o_packet_size_in_symbols <= o_packet_size_in_symbols + CNT_W'(1);
            end
            restart <= o_sym_last;
        end
    end

endmodule

// File: tb/tb_mod16_tx.sv
// -----------------------------------------------------------------------------
// tb_mod16_tx: self-checking bench for mod16_tx.
//
// A negedge scoreboard keeps a queue of expected symbols and a packet counter
// model. Table-driven mapping vectors and hand sequences cover the multi-cycle
// cases: backpressure, streaming, packets, reset and saturation. A randomized
// phase follows.
// -----------------------------------------------------------------------------
module tb_mod16_tx;
    localparam int WIDTH   = 8;
    localparam int AMP     = 32;
    localparam int CNT_W   = 13;
    localparam int SW      = 2 * WIDTH + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]              tdata;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;
    logic signed [WIDTH-1:0] sym_i;
    logic signed [WIDTH-1:0] sym_q;
    logic                    sym_valid;
    logic                    sym_last;
    logic                    sym_ready;
    logic [CNT_W-1:0]        pkt_cnt;
    logic                    busy;

    mod16_tx #(.WIDTH(WIDTH), .AMP(AMP), .CNT_W(CNT_W)) dut (
        .i_clk                    (clk),
        .i_rst                    (rst),
        .i_tdata                  (tdata),
        .i_tdata_valid            (tvalid),
        .i_tdata_last             (tlast),
        .o_tready                 (tready),
        .o_sym_i                  (sym_i),
        .o_sym_q                  (sym_q),
        .o_sym_valid              (sym_valid),
        .o_sym_last               (sym_last),
        .i_sym_ready              (sym_ready),
        .o_packet_size_in_symbols (pkt_cnt),
        .o_busy                   (busy)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [WIDTH-1:0] lvl(input logic [1:0] b);
        int t[4];
        t = '{-3, -1, 3, 1};
        return WIDTH'(t[b] * AMP);
    endfunction

    function automatic logic [SW-1:0] sym(input logic last, input logic [3:0] n);
        return {last, lvl(n[3:2]), lvl(n[1:0])};
    endfunction

    logic [SW-1:0] exp_q[$];
    int            m_cnt     = 0;
    bit            m_restart = 1'b0;
    bit            mon_on    = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            bit            m_tready;
            bit            m_xfer;
            logic [SW-1:0] e;
            m_tready = rst && (exp_q.size() == 0 || (exp_q.size() == 1 && sym_ready));
            m_xfer   = (exp_q.size() > 0) && sym_ready;
            check("sb_valid", 64'(sym_valid), 64'(exp_q.size() > 0));
            check("sb_busy", 64'(busy), 64'(exp_q.size() > 0));
            check("sb_tready", 64'(tready), 64'(m_tready));
            check("sb_count", 64'(pkt_cnt), 64'(m_cnt));
            if (exp_q.size() > 0) check("sb_symbol", 64'({sym_last, sym_i, sym_q}), 64'(exp_q[0]));
            if (!rst) begin
                exp_q.delete();
                m_cnt     = 0;
                m_restart = 1'b0;
            end else begin
                if (m_xfer) begin
                    e         = exp_q.pop_front();
                    m_cnt     = m_restart ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt);
                    m_restart = e[SW-1];
                end
                if (m_tready && tvalid) begin
                    exp_q.push_back(sym(1'b0, tdata[7:4]));
                    exp_q.push_back(sym(tlast, tdata[3:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        bit acc;
        int n;
        n      = 0;
        acc    = 1'b0;
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        while (!acc && n < 200) begin
            acc = tready;
            step();
            n++;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = 8'($urandom);
        if (!acc) check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'(0));
    endtask

    // ---------------- mapping vectors ----------------
    typedef struct {
        logic [7:0] data;
        int         hi_i;
        int         hi_q;
        int         lo_i;
        int         lo_q;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sb[4];
        bit         acc;
        int         idx;

        tbl[0] = '{8'h1B, -96, -32,  96,  32};
        tbl[1] = '{8'h01, -96, -96, -96, -32};
        tbl[2] = '{8'h23, -96,  96, -96,  32};
        tbl[3] = '{8'h45, -32, -96, -32, -32};
        tbl[4] = '{8'h67, -32,  96, -32,  32};
        tbl[5] = '{8'h89,  96, -96,  96, -32};
        tbl[6] = '{8'hAB,  96,  96,  96,  32};
        tbl[7] = '{8'hCD,  32, -96,  32, -32};
        tbl[8] = '{8'hEF,  32,  96,  32,  32};
        tbl[9] = '{8'hAA,  96,  96,  96,  96};

        rst       = 1'b0;
        tvalid    = 1'b0;
        tlast     = 1'b0;
        tdata     = 8'h00;
        sym_ready = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_valid", 64'(sym_valid), 64'(0));
        check("rst_i", 64'(sym_i), 64'(0));
        check("rst_q", 64'(sym_q), 64'(0));
        check("rst_last", 64'(sym_last), 64'(0));
        check("rst_count", 64'(pkt_cnt), 64'(0));
        check("rst_tready", 64'(tready), 64'(0));
        mon_on = 1'b1;
        rst    = 1'b1;
        step();

        // Mapping table, one single-byte packet per entry
        for (int k = 0; k < 10; k++) begin
            send_byte(tbl[k].data, 1'b1);
            check("map_hi_i", 64'(sym_i), 64'(tbl[k].hi_i));
            check("map_hi_q", 64'(sym_q), 64'(tbl[k].hi_q));
            check("map_hi_last", 64'(sym_last), 64'(0));
            step();
            check("map_lo_i", 64'(sym_i), 64'(tbl[k].lo_i));
            check("map_lo_q", 64'(sym_q), 64'(tbl[k].lo_q));
            check("map_lo_last", 64'(sym_last), 64'(1));
            check("map_cnt_hi", 64'(pkt_cnt), 64'(1));
            step();
            check("map_done_valid", 64'(sym_valid), 64'(0));
            check("map_cnt", 64'(pkt_cnt), 64'(2));
        end

        // Backpressure in S_HI
        sym_ready = 1'b0;
        send_byte(8'h5C, 1'b1);
        tvalid = 1'b1;
        tdata  = 8'hFF;
        tlast  = 1'b1;
        repeat (5) begin
            step();
            check("bp_i", 64'(sym_i), 64'(-32));
            check("bp_q", 64'(sym_q), 64'(-32));
            check("bp_valid", 64'(sym_valid), 64'(1));
            check("bp_tready", 64'(tready), 64'(0));
        end
        tvalid    = 1'b0;
        tlast     = 1'b0;
        sym_ready = 1'b1;
        step();
        check("bp_lo_i", 64'(sym_i), 64'(32));
        check("bp_lo_q", 64'(sym_q), 64'(-96));
        check("bp_lo_last", 64'(sym_last), 64'(1));
        step();
        check("bp_end_valid", 64'(sym_valid), 64'(0));
        check("bp_count", 64'(pkt_cnt), 64'(2));

        // Stream of 4 bytes at full rate
        sb     = '{8'h3C, 8'h96, 8'h0F, 8'hE1};
        idx    = 0;
        tdata  = sb[0];
        tlast  = 1'b0;
        tvalid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            check("stream_tready", 64'(tready), 64'(c % 2 == 0));
            acc = tready && tvalid;
            step();
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    tdata = sb[idx];
                    tlast = (idx == 3);
                end else begin
                    tvalid = 1'b0;
                    tlast  = 1'b0;
                end
            end
            check("stream_valid", 64'(sym_valid), 64'(1));
        end
        step();
        check("stream_end_valid", 64'(sym_valid), 64'(0));
        check("stream_count", 64'(pkt_cnt), 64'(8));

        // Two packets: 3 bytes then 2 bytes
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        wait_idle();
        check("pkt1_count", 64'(pkt_cnt), 64'(6));
        repeat (3) step();
        check("pkt1_hold", 64'(pkt_cnt), 64'(6));
        send_byte(8'h44, 1'b0);
        check("pkt2_before", 64'(pkt_cnt), 64'(6));
        step();
        check("pkt2_first", 64'(pkt_cnt), 64'(1));
        send_byte(8'h55, 1'b1);
        wait_idle();
        check("pkt2_count", 64'(pkt_cnt), 64'(4));

        // Reset after the high symbol is presented
        sym_ready = 1'b0;
        send_byte(8'h9E, 1'b1);
        check("mid_busy", 64'(busy), 64'(1));
        rst = 1'b0;
        #1;
        check("mid_rst_tready", 64'(tready), 64'(0));
        step();
        check("mid_valid", 64'(sym_valid), 64'(0));
        check("mid_count", 64'(pkt_cnt), 64'(0));
        check("mid_i", 64'(sym_i), 64'(0));
        check("mid_q", 64'(sym_q), 64'(0));
        rst       = 1'b1;
        sym_ready = 1'b1;
        repeat (4) begin
            step();
            check("mid_no_lo", 64'(sym_valid), 64'(0));
        end

        // Counter saturation
        for (int k = 0; k < 4100; k++) send_byte(8'($urandom), 1'b0);
        wait_idle();
        check("sat_count", 64'(pkt_cnt), 64'(CNT_MAX));
        send_byte(8'h5A, 1'b1);
        wait_idle();
        check("sat_last_count", 64'(pkt_cnt), 64'(CNT_MAX));
        send_byte(8'hA5, 1'b1);
        wait_idle();
        check("sat_restart", 64'(pkt_cnt), 64'(2));

        // Randomized traffic with occasional resets
        repeat (3000) begin
            tvalid    = ($urandom_range(0, 1) == 1);
            tdata     = 8'($urandom);
            tlast     = ($urandom_range(0, 3) == 0);
            sym_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) != 0);
            step();
        end
        rst       = 1'b1;
        tvalid    = 1'b0;
        sym_ready = 1'b1;
        step();
        send_byte(8'h77, 1'b1);
        wait_idle();
        check("rand_idle_valid", 64'(sym_valid), 64'(0));
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
